axis_eth_rx_fcs_strip: RTL and testbench
========================================

# axis_eth_rx_fcs_strip

Receive-side frame post-processor that sits directly downstream of the GMII frame receiver. It consumes the receiver's byte stream (FCS included, no backpressure) and removes the trailing 4 FCS bytes. It enforces minimum and maximum frame length, truncating oversize frames, and merges all error causes into a single `tuser` bit. The result is a clean payload-only stream for the MAC-side FIFO.

## Interface
- DATA_WIDTH, 8, stream width; only 8 is supported, any other value is an elaboration error.
- MIN_FRAME_LEN, 64, minimum legal length in bytes, FCS included.
- MAX_FRAME_LEN, 1518, maximum legal length in bytes, FCS included; must be < 65535.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  8  received byte.
- s_axis_tvalid  in  1  beat valid; there is no tready and every valid beat is accepted.
- s_axis_tlast  in  1  last byte of frame, which is the final FCS byte.
- s_axis_tuser  in  1  upstream error flag, meaningful only with tlast.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  output beat valid; there is no tready.
- m_axis_tlast  out  1  last payload byte.
- m_axis_tuser  out  1  frame bad, meaningful only with m_axis_tlast.
- frame_good  out  1  1-cycle pulse: frame ended with no error.
- error_runt  out  1  1-cycle pulse: frame length < MIN_FRAME_LEN.
- error_oversize  out  1  1-cycle pulse: frame length > MAX_FRAME_LEN.
- error_upstream  out  1  1-cycle pulse: s_axis_tuser was set at tlast.
- stat_frames_good  out  CNT_WIDTH  count of good frames.
- stat_frames_bad  out  CNT_WIDTH  count of bad frames.

## Operation
- **Delay buffer.** A 4-entry byte shift buffer with fill count `fill` (0..4).
  - Every accepted beat pushes one byte into the buffer.
  - If `fill == 4` before the push, the oldest byte is emitted on m_axis.
  - The last 4 bytes of a frame are therefore never emitted; they are the FCS.
- **Length counter.** A 16-bit `len` counts accepted beats of the current frame and saturates at 0xFFFF. At each beat, `len_now = len + 1`.
- **State machine**, states IDLE, PASS, DISCARD:
  - IDLE: the first valid beat sets `len=1` and `fill=1`, then moves to PASS. If that beat has tlast, apply the end-of-frame rule instead and stay in IDLE.
  - PASS, non-last beat with `len_now <= MAX_FRAME_LEN`: push, emit if full.
  - PASS, non-last beat with `len_now > MAX_FRAME_LEN`:
    - Emit the oldest byte with tlast=1, tuser=1.
    - Pulse error_oversize.
    - Clear the buffer and go to DISCARD.
  - PASS, tlast beat: apply the end-of-frame rule, then go to IDLE.
  - DISCARD: drop all beats and emit nothing. A tlast beat goes to IDLE with no further output and no pulses.
- **End-of-frame rule** (applies at the tlast beat, with L = `len_now`):
  - If `fill == 4`, emit the oldest byte with tlast=1.
  - If `fill < 4` (frame of 4 bytes or fewer), emit one filler beat with tdata=0x00, tlast=1, tuser=1.
  - `bad = s_axis_tuser | (L < MIN_FRAME_LEN) | (L > MAX_FRAME_LEN)`, and m_axis_tuser = `bad`.
  - Pulse error_upstream, error_runt and error_oversize as applicable; pulse frame_good if `!bad`.
- **Valid gaps.** s_axis_tvalid may drop mid-frame (MII mode, clk_enable); buffer, counter and state hold unchanged while it is low.
- **Back-to-back frames.** A first beat in the cycle directly after tlast is legal and starts a new frame.

## Timing
- Output is registered: one m_axis beat per accepted input beat, at most, appearing 1 cycle after that input beat.
- Payload byte k (0-based) is emitted on the cycle after input beat k+4 is accepted.
- Status pulses are asserted in the same cycle as the m_axis_tlast beat.
- Reset values: all m_axis_* = 0, all pulses = 0, stat counters = 0, state = IDLE, `fill` = 0, `len` = 0.
- Reset mid-frame clears everything; beats after reset are treated as a new frame.

## Configuration
- **ETH_RX_STATS_EN defined:** stat_frames_good increments on each frame_good pulse. stat_frames_bad increments on each bad frame end, including a truncation event. Both counters wrap modulo 2^CNT_WIDTH.
- **ETH_RX_STATS_EN not defined:** both stat ports are tied to 0 and no counter logic is generated.

## Test plan
- 64-byte frame (60 payload + FCS), tuser=0 → 60 output beats, tlast on byte 59, tuser=0, frame_good pulse, stat_frames_good=1.
- 60-byte frame → 56 beats, tuser=1, error_runt pulse, frame_good stays 0.
- 3-byte frame → exactly one beat with tdata=0x00, tlast=1, tuser=1, and an error_runt pulse.
- 1600-byte frame with MAX_FRAME_LEN=1518 → 1515 beats, the last with tlast=1, tuser=1; one error_oversize pulse; remaining input dropped; a following 64-byte frame passes cleanly.
- 100-byte frame with s_axis_tuser=1 on tlast and tvalid toggling every other cycle → 96 beats, each emitted 1 cycle after its input beat, final tuser=1, error_upstream pulse.
- rst asserted at byte 30 of a frame, then 40 further bytes ending in tlast → no output during reset; afterwards a 36-beat frame with tuser=1 and error_runt; stat counters read 0 → 1 bad.

Source files
------------

// File: rtl/axis_eth_rx_fcs_strip_if.sv
// Byte-wide AXI-Stream bundle with no tready; tuser flags a bad frame alongside tlast.
interface axis_eth_rx_fcs_strip_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/axis_eth_rx_fcs_strip.sv
// Strips the 4-byte FCS from received frames, enforces min/max length and merges error causes.
// Optional statistics counters are built only when ETH_RX_STATS_EN is defined.
module axis_eth_rx_fcs_strip #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  axis_eth_rx_fcs_strip_if.slave   s_axis,
  axis_eth_rx_fcs_strip_if.master  m_axis,
  output logic                     frame_good_o,
  output logic                     error_runt_o,
  output logic                     error_oversize_o,
  output logic                     error_upstream_o,
  output logic [CNT_WIDTH-1:0]     stat_frames_good_o,
  output logic [CNT_WIDTH-1:0]     stat_frames_bad_o
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned FILL_W = 3;
  localparam int unsigned DEPTH  = 4;
  localparam logic [LEN_W-1:0]  MIN_LEN = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_FRAME_LEN);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(DEPTH);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("axis_eth_rx_fcs_strip: DATA_WIDTH must be 8");
  end
  if (MAX_FRAME_LEN >= 65535) begin : g_bad_max_len
    $error("axis_eth_rx_fcs_strip: MAX_FRAME_LEN must be below 65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DISCARD} state_e;

  state_e                           state_q, state_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] dly_q, dly_d;
  logic [FILL_W-1:0]                fill_q, fill_d;
  logic [LEN_W-1:0]                 len_q, len_d;

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  good_q, good_d;
  logic                  runt_q, runt_d;
  logic                  over_q, over_d;
  logic                  upstream_q, upstream_d;

  logic [LEN_W-1:0] len_now;
  logic             is_runt;
  logic             is_over;
  logic             frame_bad;

  // Next-state: delay line, length counter, FSM and the registered output beat
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    fill_d     = fill_q;
    len_d      = len_q;
    tdata_d    = '0;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    good_d     = 1'b0;
    runt_d     = 1'b0;
    over_d     = 1'b0;
    upstream_d = 1'b0;

    len_now   = (len_q == '1) ? len_q : len_q + LEN_W'(1);
    is_runt   = len_now < MIN_LEN;
    is_over   = len_now > MAX_LEN;
    frame_bad = s_axis.tuser | is_runt | is_over;

    if (s_axis.tvalid) begin
      unique case (state_q)
        // IDLE always holds fill=0, len=0, so the first beat follows the PASS path
        S_IDLE, S_PASS: begin
          if (s_axis.tlast) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            if (fill_q == FULL) begin
              tdata_d = dly_q[0];
              tuser_d = frame_bad;
            end else begin
              tuser_d = 1'b1;
            end
            upstream_d = s_axis.tuser;
            runt_d     = is_runt;
            over_d     = is_over;
            good_d     = ~frame_bad;
            fill_d     = '0;
            len_d      = '0;
            state_d    = S_IDLE;
          end else if (is_over) begin
            tvalid_d = 1'b1;
            tdata_d  = dly_q[0];
            tlast_d  = 1'b1;
            tuser_d  = 1'b1;
            over_d   = 1'b1;
            fill_d   = '0;
            len_d    = '0;
            state_d  = S_DISCARD;
          end else begin
            if (fill_q == FULL) begin
              tvalid_d = 1'b1;
              tdata_d  = dly_q[0];
              dly_d    = {s_axis.tdata, dly_q[DEPTH-1:1]};
            end else begin
              dly_d[fill_q[1:0]] = s_axis.tdata;
              fill_d             = fill_q + FILL_W'(1);
            end
            len_d   = len_now;
            state_d = S_PASS;
          end
        end
        S_DISCARD: begin
          if (s_axis.tlast) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      fill_q     <= '0;
      len_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      good_q     <= 1'b0;
      runt_q     <= 1'b0;
      over_q     <= 1'b0;
      upstream_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      fill_q     <= fill_d;
      len_q      <= len_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      good_q     <= good_d;
      runt_q     <= runt_d;
      over_q     <= over_d;
      upstream_q <= upstream_d;
    end
  end

  assign m_axis.tdata     = tdata_q;
  assign m_axis.tvalid    = tvalid_q;
  assign m_axis.tlast     = tlast_q;
  assign m_axis.tuser     = tuser_q;
  assign frame_good_o     = good_q;
  assign error_runt_o     = runt_q;
  assign error_oversize_o = over_q;
  assign error_upstream_o = upstream_q;

`ifdef ETH_RX_STATS_EN
  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;

  // Every bad frame end, truncation included, leaves as a tlast beat with tuser set
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (good_d) begin
      good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
    end
    if (tvalid_d && tlast_d && tuser_d) begin
      bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign stat_frames_good_o = good_cnt_q;
  assign stat_frames_bad_o  = bad_cnt_q;
`else
  assign stat_frames_good_o = '0;
  assign stat_frames_bad_o  = '0;
`endif

endmodule

// File: tb/tb_axis_eth_rx_fcs_strip.sv
// Self-checking bench for axis_eth_rx_fcs_strip: directed vector table plus randomized frames
// checked against a frame-level reference model.
module tb_axis_eth_rx_fcs_strip;

  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned CNT_W   = 32;
`ifdef ETH_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        user;
    logic [31:0] cyc;
  } in_rec_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        valid;
    logic        last;
    logic        user;
    logic        good;
    logic        runt;
    logic        over;
    logic        up;
    logic [31:0] cyc;
  } out_rec_t;

  typedef struct {
    int len;
    int user;
    int gap;
    int beats;
    int last_user;
    int good;
    int runt;
    int over;
    int up;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_eth_rx_fcs_strip_if #(.DATA_WIDTH(8)) s_if ();
  axis_eth_rx_fcs_strip_if #(.DATA_WIDTH(8)) m_if ();

  logic             frame_good, error_runt, error_oversize, error_upstream;
  logic [CNT_W-1:0] stat_good, stat_bad;

  axis_eth_rx_fcs_strip #(
    .DATA_WIDTH   (8),
    .MIN_FRAME_LEN(MIN_LEN),
    .MAX_FRAME_LEN(MAX_LEN),
    .CNT_WIDTH    (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .frame_good_o      (frame_good),
    .error_runt_o      (error_runt),
    .error_oversize_o  (error_oversize),
    .error_upstream_o  (error_upstream),
    .stat_frames_good_o(stat_good),
    .stat_frames_bad_o (stat_bad)
  );

  int checks = 0;
  int errors = 0;
  int exp_good = 0;
  int exp_bad = 0;
  int rst_leak = 0;
  int mcyc = 0;
  bit rst_prev = 1'b0;
  in_rec_t  inq[$];
  out_rec_t outq[$];

  // Mid-cycle monitor: inputs seen here are taken at the next edge, outputs reflect the last one
  always @(negedge clk) begin
    out_rec_t o;
    in_rec_t  i;
    mcyc++;
    if (rst_prev && (m_if.tvalid === 1'b1 || frame_good === 1'b1 || error_runt === 1'b1 ||
                     error_oversize === 1'b1 || error_upstream === 1'b1))
      rst_leak++;
    if (m_if.tvalid === 1'b1 || frame_good === 1'b1 || error_runt === 1'b1 ||
        error_oversize === 1'b1 || error_upstream === 1'b1) begin
      o.data  = m_if.tdata;
      o.valid = m_if.tvalid;
      o.last  = m_if.tlast;
      o.user  = m_if.tuser;
      o.good  = frame_good;
      o.runt  = error_runt;
      o.over  = error_oversize;
      o.up    = error_upstream;
      o.cyc   = 32'(mcyc);
      outq.push_back(o);
    end
    if (rst === 1'b0 && s_if.tvalid === 1'b1) begin
      i.data = s_if.tdata;
      i.last = s_if.tlast;
      i.user = s_if.tuser;
      i.cyc  = 32'(mcyc);
      inq.push_back(i);
    end
    rst_prev = (rst === 1'b1);
  end

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (n) step();
  endtask

  // gap: 0 contiguous, 1 tvalid toggles every other cycle, 2 occasional random holes
  task automatic send_frame(input int n, input int u, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      if (i > 0 && gap == 1) g = 1;
      if (i > 0 && gap == 2) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (g > 0) idle(g);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'($urandom);
      s_if.tlast  = (i == n - 1);
      s_if.tuser  = (i == n - 1) && (u != 0);
      step();
    end
  endtask

  // Frame-level model: payload = all but the last 4 bytes, capped at MAX-3 when truncated;
  // each payload byte k leaves one cycle after input beat k+4.
  function automatic void build_model(input in_rec_t fr[$], output out_rec_t exp[$]);
    int n, nout;
    bit u, runt, over, good;
    out_rec_t r;
    exp.delete();
    n = fr.size();
    if (n == 0) return;
    u    = fr[n-1].user;
    runt = n < int'(MIN_LEN);
    over = n > int'(MAX_LEN);
    if (n > int'(MAX_LEN) + 1) begin
      nout = int'(MAX_LEN) - 3;
      u    = 1'b0;
      runt = 1'b0;
    end else begin
      nout = n - 4;
    end
    good = !(u || runt || over);
    if (nout <= 0) begin
      r       = '0;
      r.valid = 1'b1;
      r.last  = 1'b1;
      r.user  = 1'b1;
      r.good  = good;
      r.runt  = runt;
      r.over  = over;
      r.up    = u;
      r.cyc   = fr[n-1].cyc + 32'd1;
      exp.push_back(r);
    end else begin
      for (int k = 0; k < nout; k++) begin
        r       = '0;
        r.data  = fr[k].data;
        r.valid = 1'b1;
        r.cyc   = fr[k+4].cyc + 32'd1;
        if (k == nout - 1) begin
          r.last = 1'b1;
          r.user = !good;
          r.good = good;
          r.runt = runt;
          r.over = over;
          r.up   = u;
        end
        exp.push_back(r);
      end
    end
  endfunction

  task automatic check_frame(input string name, input bit use_vec, input vec_t v);
    in_rec_t  fr[$];
    in_rec_t  ir;
    out_rec_t exp[$];
    out_rec_t got[$];
    out_rec_t lastr, g0, e0;
    int nbad, first;
    bit stop;
    int pv;
    while (inq.size() > 0) begin
      ir = inq.pop_front();
      fr.push_back(ir);
      if (ir.last) break;
    end
    build_model(fr, exp);
    stop = 1'b0;
    while (outq.size() > 0 && !stop) begin
      lastr = outq.pop_front();
      got.push_back(lastr);
      stop = lastr.last | lastr.good | lastr.runt | lastr.over | lastr.up;
    end
    check({name, " beats"}, got.size() == exp.size(),
          $sformatf("got %0d beats, model expects %0d", got.size(), exp.size()));
    nbad = 0;
    first = -1;
    g0 = '0;
    e0 = '0;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      if (got[i] != exp[i]) begin
        nbad++;
        if (first < 0) begin
          first = i;
          g0 = got[i];
          e0 = exp[i];
        end
      end
    end
    check({name, " model"}, nbad == 0,
          $sformatf("%0d beats differ, first #%0d got %h required %h", nbad, first, g0, e0));
    lastr = (got.size() > 0) ? got[got.size()-1] : '0;
    if (use_vec) begin
      check({name, " count"}, got.size() == v.beats,
            $sformatf("got %0d beats, required %0d", got.size(), v.beats));
      check({name, " tlast"}, lastr.last == 1'b1 && lastr.valid == 1'b1,
            $sformatf("final valid/last %b%b, required 11", lastr.valid, lastr.last));
      check({name, " tuser"}, int'(lastr.user) == v.last_user,
            $sformatf("final tuser %0d, required %0d", lastr.user, v.last_user));
      pv = v.good * 8 + v.runt * 4 + v.over * 2 + v.up;
      check({name, " pulses"}, int'({lastr.good, lastr.runt, lastr.over, lastr.up}) == pv,
            $sformatf("good/runt/over/up %b, required %b",
                      {lastr.good, lastr.runt, lastr.over, lastr.up}, 4'(pv)));
    end
    if (exp.size() > 0) begin
      if (exp[exp.size()-1].good) exp_good++;
      if (exp[exp.size()-1].user) exp_bad++;
    end
  endtask

  task automatic check_stats(input string name);
    check({name, " stat_good"}, stat_good == (STATS ? CNT_W'(exp_good) : CNT_W'(0)),
          $sformatf("got %0d, required %0d", stat_good, STATS ? exp_good : 0));
    check({name, " stat_bad"}, stat_bad == (STATS ? CNT_W'(exp_bad) : CNT_W'(0)),
          $sformatf("got %0d, required %0d", stat_bad, STATS ? exp_bad : 0));
  endtask

  initial begin
    vec_t tbl[14];
    vec_t none;
    int n, u;
    //         len  usr gap beats lu good runt over up
    tbl[0]  = '{64,   0, 0, 60,   0, 1, 0, 0, 0};
    tbl[1]  = '{60,   0, 0, 56,   1, 0, 1, 0, 0};
    tbl[2]  = '{3,    0, 0, 1,    1, 0, 1, 0, 0};
    tbl[3]  = '{1600, 0, 0, 1515, 1, 0, 0, 1, 0};
    tbl[4]  = '{64,   0, 0, 60,   0, 1, 0, 0, 0};
    tbl[5]  = '{100,  1, 1, 96,   1, 0, 0, 0, 1};
    tbl[6]  = '{4,    0, 0, 1,    1, 0, 1, 0, 0};
    tbl[7]  = '{5,    0, 0, 1,    1, 0, 1, 0, 0};
    tbl[8]  = '{65,   0, 2, 61,   0, 1, 0, 0, 0};
    tbl[9]  = '{1518, 0, 0, 1514, 0, 1, 0, 0, 0};
    tbl[10] = '{1519, 1, 0, 1515, 1, 0, 0, 1, 1};
    tbl[11] = '{1600, 1, 0, 1515, 1, 0, 0, 1, 0};
    tbl[12] = '{1,    1, 0, 1,    1, 0, 1, 0, 1};
    tbl[13] = '{63,   0, 0, 59,   1, 0, 1, 0, 0};
    none    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset outputs",
          {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata,
           frame_good, error_runt, error_oversize, error_upstream} == 15'd0,
          $sformatf("valid/last/user/data/pulses %b, required all 0",
                    {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata,
                     frame_good, error_runt, error_oversize, error_upstream}));
    check_stats("reset");
    inq.delete();
    outq.delete();

    for (int i = 0; i < 14; i++) begin
      send_frame(tbl[i].len, tbl[i].user, tbl[i].gap);
      idle(3);
      check_frame($sformatf("vec%0d_len%0d", i, tbl[i].len), 1'b1, tbl[i]);
    end
    check_stats("table");

    // Back-to-back: second frame starts the cycle right after tlast
    send_frame(64, 0, 0);
    send_frame(70, 1, 0);
    idle(3);
    check_frame("b2b_first", 1'b1, '{64, 0, 0, 60, 0, 1, 0, 0, 0});
    check_frame("b2b_second", 1'b1, '{70, 1, 0, 66, 1, 0, 0, 0, 1});

    for (int b = 0; b < 8; b++) begin
      for (int f = 0; f < 5; f++) begin
        case ($urandom_range(0, 9))
          0, 1:    n = int'($urandom_range(1515, 1525));
          2, 3:    n = int'($urandom_range(58, 70));
          default: n = int'($urandom_range(1, 140));
        endcase
        u = ($urandom_range(0, 3) == 0) ? 1 : 0;
        send_frame(n, u, int'($urandom_range(0, 2)));
        idle(int'($urandom_range(0, 1)));
      end
      idle(3);
      for (int f = 0; f < 5; f++) check_frame($sformatf("rand%0d_%0d", b, f), 1'b0, none);
    end
    check_stats("random");

    // Reset in the middle of a frame while beats keep arriving
    for (int i = 0; i < 30; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'($urandom);
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      step();
    end
    rst = 1'b1;
    rst_leak = 0;
    repeat (3) begin
      s_if.tdata = 8'($urandom);
      step();
    end
    rst = 1'b0;
    inq.delete();
    outq.delete();
    exp_good = 0;
    exp_bad = 0;
    check_stats("after_reset");
    send_frame(40, 0, 0);
    idle(3);
    check("reset quiet", rst_leak == 0,
          $sformatf("%0d output beats/pulses during reset, required 0", rst_leak));
    check_frame("post_reset", 1'b1, '{40, 0, 0, 36, 1, 0, 1, 0, 0});
    check_stats("post_reset");

    idle(4);
    check("drain", inq.size() == 0 && outq.size() == 0,
          $sformatf("leftover inputs %0d outputs %0d, required 0 0", inq.size(), outq.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
